prn_seq_chk: RTL and testbench



---
 rtl/prn_pkg.sv | 18 +
 rtl/prn_err_window.sv | 52 +++++
 rtl/prn_seq_chk.sv | 124 ++++++++++++
 tb/tb_prn_seq_chk.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prn_pkg.sv
// rtl/prn_pkg.sv - shared 10-bit XNOR PRN polynomial and checker state type
package prn_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 2;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prn_state_e;

  // b[t] = ~(b[t-10] ^ b[t-3]) with h[k] holding b[t-1-k]
  function automatic logic prn_next_bit(input logic [LFSR_W-1:0] h);
    return ~(h[TAP_HI] ^ h[TAP_LO]);
  endfunction

endpackage

// File: rtl/prn_err_window.sv
// rtl/prn_err_window.sv - per-window sample and error counting with loss-of-sync detection
module prn_err_window #(
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic err,
  input  logic clear,
  output logic loss
);

  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int EC_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN_LEN - 1);
  localparam logic [EC_W-1:0] LOSS_LAST = EC_W'(LOSS_THRESH - 1);

  logic [WC_W-1:0] win_cnt_q, win_cnt_d;
  logic [EC_W-1:0] win_err_q, win_err_d;

  // The error count never exceeds LOSS_THRESH-1, so equality is enough here
  assign loss = valid && err && (win_err_q == LOSS_LAST);

  always_comb begin
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    if (clear) begin
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (valid) begin
      if (loss || (win_cnt_q == WIN_LAST)) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        win_err_d = win_err_q + EC_W'(err);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end

endmodule

// File: rtl/prn_seq_chk.sv
// rtl/prn_seq_chk.sv - self-synchronising XNOR PRN checker with flywheel, BER counters and sync-loss
module prn_seq_chk
  import prn_pkg::*;
#(
  parameter int LOCK_THRESH = 32,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_stream,
  input  logic             bit_valid,
  output logic             locked,
  output logic             bit_err,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int RUN_W = $clog2(LOCK_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_THRESH - 1);
  localparam logic [3:0]       FILL_DONE = 4'(LFSR_W);

  prn_state_e        state_q, state_d;
  logic [LFSR_W-1:0] h_q, h_d;
  logic [3:0]        fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic              bit_err_q, bit_err_d;
  logic              sync_loss_q, sync_loss_d;
  logic              pred, mism, win_valid, lock_hit, win_loss;

  assign pred      = prn_next_bit(h_q);
  assign mism      = data_in_stream != pred;
  assign win_valid = bit_valid && (state_q == LOCKED);
  // The all-ones history is the XNOR lock-up state and must never count as a match
  assign lock_hit  = bit_valid && (state_q == SEARCH) && (fill_q == FILL_DONE)
                     && !mism && (h_q != '1) && (run_q == RUN_LAST);

  prn_err_window #(
    .WIN_LEN    (WIN_LEN),
    .LOSS_THRESH(LOSS_THRESH)
  ) u_err_window (
    .clk  (clk),
    .rst  (rst),
    .valid(win_valid),
    .err  (mism),
    .clear(lock_hit),
    .loss (win_loss)
  );

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    run_d       = run_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    bit_err_d   = 1'b0;
    sync_loss_d = 1'b0;
    if (bit_valid) begin
      if (state_q == SEARCH) begin
        h_d = {h_q[LFSR_W-2:0], data_in_stream};
        if (fill_q != FILL_DONE) begin
          fill_d = fill_q + 1'b1;
        end else if (lock_hit) begin
          state_d     = LOCKED;
          run_d       = '0;
          err_count_d = '0;
          bit_count_d = '0;
        end else if (mism || (h_q == '1)) begin
          run_d = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end else begin
        // Flywheel: the local copy advances on its own prediction
        h_d = {h_q[LFSR_W-2:0], pred};
        if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
        if (mism) begin
          bit_err_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        end
        if (win_loss) begin
          sync_loss_d = 1'b1;
          state_d     = SEARCH;
          fill_d      = '0;
          run_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      h_q         <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      bit_err_q   <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      bit_err_q   <= bit_err_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign bit_err   = bit_err_q;
  assign sync_loss = sync_loss_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prn_seq_chk.sv
// tb/tb_prn_seq_chk.sv - randomized self-checking bench for prn_seq_chk against a sequence-law model
module tb_prn_seq_chk;

  localparam int LOCK_THRESH = 32;
  localparam int WIN_LEN     = 64;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam int VW          = 2 * CNT_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in_stream = 1'b0;
  logic bit_valid = 1'b0;
  logic locked, bit_err, sync_loss;
  logic [CNT_W-1:0] err_count, bit_count;

  prn_seq_chk #(
    .LOCK_THRESH(LOCK_THRESH),
    .WIN_LEN    (WIN_LEN),
    .LOSS_THRESH(LOSS_THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_stream(data_in_stream),
    .bit_valid     (bit_valid),
    .locked        (locked),
    .bit_err       (bit_err),
    .sync_loss     (sync_loss),
    .err_count     (err_count),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transmit generator: bit list, oldest first, following b[t] = ~(b[t-10] ^ b[t-3])
  int g_hist[$];
  // Receiver model: last ten bits of its own view of the sequence, oldest first
  int m_hist[$];
  int m_locked, m_fill, m_run, m_err, m_bit, m_wcnt, m_werr, e_bit_err, e_sync_loss;

  wire [VW-1:0] dut_vec = {locked, bit_err, sync_loss, err_count, bit_count};

  function automatic logic [VW-1:0] exp_vec();
    return {1'(m_locked), 1'(e_bit_err), 1'(e_sync_loss), CNT_W'(m_err), CNT_W'(m_bit)};
  endfunction

  task automatic gen_seed(input logic [9:0] s);
    g_hist.delete();
    for (int i = 9; i >= 0; i--) g_hist.push_back(int'(s[i]));
  endtask

  function automatic int gen_next();
    int b;
    b = 1 - (g_hist[0] ^ g_hist[7]);
    g_hist.push_back(b);
    void'(g_hist.pop_front());
    return b;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    repeat (10) m_hist.push_back(0);
    m_locked = 0; m_fill = 0; m_run = 0; m_err = 0; m_bit = 0;
    m_wcnt = 0; m_werr = 0; e_bit_err = 0; e_sync_loss = 0;
  endtask

  task automatic model_sample(input int d);
    int p, ones;
    e_bit_err = 0;
    e_sync_loss = 0;
    p = 1 - (m_hist[0] ^ m_hist[7]);
    if (m_locked == 0) begin
      ones = 0;
      foreach (m_hist[i]) ones += m_hist[i];
      if (m_fill < 10) m_fill++;
      else if (d == p && ones != 10) m_run++;
      else m_run = 0;
      m_hist.push_back(d);
      if (m_run == LOCK_THRESH) begin
        m_locked = 1; m_run = 0; m_err = 0; m_bit = 0; m_wcnt = 0; m_werr = 0;
      end
    end else begin
      m_hist.push_back(p);
      m_bit = (m_bit < CMAX) ? m_bit + 1 : CMAX;
      m_wcnt++;
      if (d != p) begin
        e_bit_err = 1;
        m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
        m_werr++;
      end
      if (m_werr >= LOSS_THRESH) begin
        e_sync_loss = 1; m_locked = 0; m_fill = 0; m_run = 0; m_wcnt = 0; m_werr = 0;
      end else if (m_wcnt == WIN_LEN) begin
        m_wcnt = 0; m_werr = 0;
      end
    end
    void'(m_hist.pop_front());
  endtask

  task automatic step(input logic v, input logic d);
    bit_valid = v;
    data_in_stream = d;
    @(posedge clk);
    #1;
    if (v) model_sample(int'(d));
    else begin
      e_bit_err = 0;
      e_sync_loss = 0;
    end
  endtask

  task automatic send(input logic v, input logic flip);
    logic d;
    if (v) d = 1'(gen_next()) ^ flip;
    else d = 1'($urandom);
    step(v, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b1;
    data_in_stream = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [9:0] rand_seed();
    return 10'($urandom_range(0, 1022));
  endfunction

  task automatic lock_up(input logic [9:0] s);
    do_reset();
    gen_seed(s);
    repeat (10 + LOCK_THRESH) send(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_vec !== '0) begin
        failures++;
        $display("FAIL reset_state cycle %0d: got %h want 0", i, dut_vec);
      end
      send(1'b0, 1'b0);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    gen_seed(10'h155);
    for (int i = 1; i <= 42; i++) begin
      send(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL clean_lock sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i >= 41) begin
        checks++;
        if (locked !== (i == 42)) begin
          failures++;
          $display("FAIL lock_time sample %0d: locked=%b want %b", i, locked, i == 42);
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL clean_run sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bit_count !== CNT_W'(100) || err_count !== '0) begin
      failures++;
      $display("FAIL clean_counts: bit=%0d err=%0d want 100 0", bit_count, err_count);
    end
  endtask

  task automatic test_single_error();
    int pos, pulses;
    lock_up(rand_seed());
    pos = $urandom_range(5, 60);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, i == pos);
      if (bit_err === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL single_err sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || err_count !== CNT_W'(1) || locked !== 1'b1) begin
      failures++;
      $display("FAIL single_err_summary: pulses=%0d err=%0d locked=%b want 1 1 1",
               pulses, err_count, locked);
    end
  endtask

  task automatic test_loss_threshold();
    bit flip1[64];
    bit flip2[64];
    int last;
    lock_up(rand_seed());
    for (int k = 0; k < 64; k++) begin flip1[k] = 0; flip2[k] = 0; end
    for (int k = 0; k < 7; k++) flip1[k * 9 + $urandom_range(0, 8)] = 1;
    last = 0;
    for (int k = 0; k < 8; k++) begin
      last = k * 7 + $urandom_range(0, 6);
      flip2[last] = 1;
    end
    for (int i = 0; i < 64; i++) begin
      send(1'b1, flip1[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL loss7 sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== CNT_W'(7)) begin
      failures++;
      $display("FAIL loss7_summary: locked=%b err=%0d want 1 7", locked, err_count);
    end
    for (int i = 0; i <= last; i++) begin
      send(1'b1, flip2[i]);
      checks++;
      if (dut_vec !== exp_vec() || sync_loss !== (i == last)) begin
        failures++;
        $display("FAIL loss8 sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b0 || err_count !== CNT_W'(15) || bit_count !== CNT_W'(65 + last)) begin
      failures++;
      $display("FAIL loss8_summary: locked=%b err=%0d bit=%0d want 0 15 %0d",
               locked, err_count, bit_count, 65 + last);
    end
    for (int i = 1; i <= 42; i++) begin
      send(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec() || (i >= 41 && locked !== (i == 42))) begin
        failures++;
        $display("FAIL relock sample %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_lockup_stream();
    int seen;
    do_reset();
    gen_seed(10'h3FF);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b1, 1'b0);
      if (locked !== 1'b0) seen++;
      if (i % 100 == 99) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL lockup sample %0d: got %h want %h", i, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL lockup_never_locks: locked cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_gapped_valid();
    int nvalid;
    do_reset();
    gen_seed(rand_seed());
    nvalid = 0;
    for (int c = 0; c < 200; c++) begin
      send(c % 3 == 0, (c > 150) && ($urandom_range(0, 7) == 0));
      if (c % 3 == 0) nvalid++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL gapped cycle %0d: got %h want %h", c, dut_vec, exp_vec());
      end
      if (c == 122 || c == 123 || c == 124) begin
        checks++;
        if (locked !== (nvalid >= 42)) begin
          failures++;
          $display("FAIL gapped_lock cycle %0d: locked=%b want %b", c, locked, nvalid >= 42);
        end
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    lock_up(rand_seed());
    repeat (20) send(1'b1, $urandom_range(0, 5) == 0);
    send(1'b1, 1'b1);
    rst = 1'b1;
    bit_valid = 1'b1;
    data_in_stream = ~1'(gen_next());
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      failures++;
      $display("FAIL reset_mid_lock: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_saturation();
    lock_up(rand_seed());
    repeat (300) send(1'b1, 1'b0);
    checks++;
    if (bit_count !== CNT_W'(CMAX) || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL bit_count_saturate: got %0d want %0d", bit_count, CMAX);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gen_seed(rand_seed());
    for (int c = 0; c < 3000; c++) begin
      send($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cycle %0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_threshold();
    test_lockup_stream();
    test_gapped_valid();
    test_reset_mid_lock();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
